// File: rtl/button_pad_decoder_if.sv
// Bundles the raw button pins and the decoded press events of the Simon button front end.
// The master side drives the raw pins; the slave side is the decoder.
interface button_pad_decoder_if;
  logic       btnU;
  logic       btnR;
  logic       btnD;
  logic       btnL;
  logic       btnC;
  logic       press_valid;
  logic [3:0] press_code;
  logic       start_pulse;
  logic       chord_err;
  logic [4:0] held;

  modport master (
    output btnU, btnR, btnD, btnL, btnC,
    input  press_valid, press_code, start_pulse, chord_err, held
  );

  modport slave (
    input  btnU, btnR, btnD, btnL, btnC,
    output press_valid, press_code, start_pulse, chord_err, held
  );
endinterface

// File: rtl/button_pad_decoder.sv
// Turns five raw push buttons into clean one-cycle press events.
// Each button is synchronised, debounced, and edge-detected. A lockout FSM allows one event per press.
module button_pad_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic                 clk,
  input logic                 rst,
  button_pad_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_e;

  // Bit order is {C,L,D,R,U}, so bits [3:0] line up with the LED one-hot codes.
  logic [4:0]       raw;
  logic [4:0]       sync1_q;
  logic [4:0]       sync2_q;
  logic [4:0]       stable_q;
  logic [4:0]       stable_d;
  logic [4:0]       stableDly_q;
  logic [4:0]       rise;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [3:0]       dirRise;
  logic [3:0]       dirStable;
  logic             singleRise;
  state_e           state_q;
  logic             pressValid_q;
  logic [3:0]       pressCode_q;
  logic             chordErr_q;
  logic             startPulse_q;

  assign raw = {bus.btnC, bus.btnL, bus.btnD, bus.btnR, bus.btnU};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // The count restarts whenever the input agrees with the stable level again.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q    <= '0;
      stableDly_q <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise       = stable_q & ~stableDly_q;
  assign dirRise    = rise[3:0];
  assign dirStable  = stable_q[3:0];
  assign singleRise = (dirRise != 4'b0000) && ((dirRise & (dirRise - 4'd1)) == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      startPulse_q <= 1'b0;
    end else begin
      startPulse_q <= rise[4];
    end
  end

  // A press is accepted only when it is the sole directional button down; anything else is a chord.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pressValid_q <= 1'b0;
      pressCode_q  <= 4'b0000;
      chordErr_q   <= 1'b0;
    end else begin
      pressValid_q <= 1'b0;
      pressCode_q  <= 4'b0000;
      chordErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dirRise != 4'b0000) begin
            if (singleRise && ((dirStable & ~dirRise) == 4'b0000)) begin
              pressValid_q <= 1'b1;
              pressCode_q  <= dirRise;
            end else begin
              chordErr_q <= 1'b1;
            end
            state_q <= PRESSED;
          end
        end
        PRESSED: begin
          if (dirRise != 4'b0000) begin
            chordErr_q <= 1'b1;
          end else if (dirStable == 4'b0000) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.press_valid = pressValid_q;
  assign bus.press_code  = pressCode_q;
  assign bus.start_pulse = startPulse_q;
  assign bus.chord_err   = chordErr_q;
  assign bus.held        = stable_q;

endmodule
